// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer: debounced push button stepping two LEDs through modes.
// Optional LONG_PRESS_EN: a long hold forces mode OFF and pulses long_press.
module led_mode_sequencer #(
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter int BLINK_CYCLES      = 12500000,
   parameter int LONG_PRESS_CYCLES = 100000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_button,
   output logic       led_on_0,
   output logic       led_on_1,
   output logic [2:0] mode,
   output logic       press_pulse,
   output logic       long_press
);

   typedef enum logic [2:0] {
      OFF   = 3'd0,
      L0    = 3'd1,
      L1    = 3'd2,
      BOTH  = 3'd3,
      ALT   = 3'd4,
      BLINK = 3'd5
   } mode_e;

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int BW = $clog2(BLINK_CYCLES);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
      $error("DEBOUNCE_CYCLES must be at least 2");
   end
   if (BLINK_CYCLES < 2) begin : g_bad_bl
      $error("BLINK_CYCLES must be at least 2");
   end
   if (LONG_PRESS_CYCLES < 1) begin : g_bad_lp
      $error("LONG_PRESS_CYCLES must be at least 1");
   end

   logic          sync1;
   logic          sync2;
   logic          stable;
   logic          stable_d;
   logic [DW-1:0] db_cnt;
   logic          rise;
   logic          long_hit;
   logic [2:0]    mode_q;
   logic [2:0]    mode_next;
   logic [BW-1:0] blink_cnt;
   logic          phase;
   logic          led0_next;
   logic          led1_next;
   logic          pp_q;
   logic          lp_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= push_button;
         sync2 <= sync1;
      end
   end

   // stable flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt   <= '0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
      end else begin
         stable_d <= stable;
         if (sync2 == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            stable <= ~stable;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign rise = stable & ~stable_d;

`ifdef LONG_PRESS_EN
   localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);
   localparam logic [HW-1:0] HOLD_HIT = HW'(LONG_PRESS_CYCLES - 1);

   logic [HW-1:0] hold_cnt;

   // saturates so a single hold fires at most once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
      end else if (!stable) begin
         hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

   assign long_hit = stable & (hold_cnt == HOLD_HIT);
`else
   assign long_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= OFF;
      end else begin
         mode_q <= mode_next;
      end
   end

   always_comb begin
      mode_next = mode_q;
      unique case (mode_q)
         OFF:     if (rise) mode_next = L0;
         L0:      if (rise) mode_next = L1;
         L1:      if (rise) mode_next = BOTH;
         BOTH:    if (rise) mode_next = ALT;
         ALT:     if (rise) mode_next = BLINK;
         BLINK:   if (rise) mode_next = OFF;
         default: mode_next = OFF;
      endcase
      if (long_hit) begin
         mode_next = OFF;
      end
   end

   // restart on mode change so every pattern opens with its on half
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (mode_next != mode_q) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (blink_cnt == BL_LAST) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   always_comb begin
      led0_next = 1'b0;
      led1_next = 1'b0;
      unique case (mode_q)
         L0: led0_next = 1'b1;
         L1: led1_next = 1'b1;
         BOTH: begin
            led0_next = 1'b1;
            led1_next = 1'b1;
         end
         ALT: begin
            led0_next = phase;
            led1_next = ~phase;
         end
         BLINK: begin
            led0_next = phase;
            led1_next = phase;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_on_0 <= 1'b0;
         led_on_1 <= 1'b0;
         pp_q     <= 1'b0;
         lp_q     <= 1'b0;
      end else begin
         led_on_0 <= led0_next;
         led_on_1 <= led1_next;
         pp_q     <= rise;
         lp_q     <= long_hit;
      end
   end

   assign mode        = mode_q;
   assign press_pulse = pp_q;
   assign long_press  = lp_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb_led_mode_sequencer: vector table, hand-written corner sequences and a
// random button run checked against a counting model of the sequencer.
module tb_led_mode_sequencer;

   localparam int DEB = 4;
   localparam int BLK = 3;
   localparam int LNG = 20;
`ifdef LONG_PRESS_EN
   localparam bit LP_EN = 1'b1;
`else
   localparam bit LP_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       push_button = 1'b0;
   logic       led_on_0;
   logic       led_on_1;
   logic [2:0] mode;
   logic       press_pulse;
   logic       long_press;
   bit         clk_run = 1'b1;

   led_mode_sequencer #(
      .DEBOUNCE_CYCLES  (DEB),
      .BLINK_CYCLES     (BLK),
      .LONG_PRESS_CYCLES(LNG)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .push_button(push_button),
      .led_on_0   (led_on_0),
      .led_on_1   (led_on_1),
      .mode       (mode),
      .press_pulse(press_pulse),
      .long_press (long_press)
   );

   always #5 if (clk_run) clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int pp_seen  = 0;
   int lp_seen  = 0;

   // model state: edges since reset, recent samples, mode history
   int edge_n;
   int m_mode;
   int m_tchg;
   int m_rise_edge;
   bit m_stable;
   bit m_rose;
   bit b_hist[$];
   bit seen_q[$];
   bit e_l0, e_l1, e_pp, e_lp;

   task automatic check(input string name, input logic [31:0] act,
                        input int exp);
      n_checks++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      edge_n      = 0;
      m_mode      = 0;
      m_tchg      = 0;
      m_rise_edge = -1000000;
      m_stable    = 1'b0;
      m_rose      = 1'b0;
      b_hist.delete();
      seen_q.delete();
      e_l0 = 1'b0;
      e_l1 = 1'b0;
      e_pp = 1'b0;
      e_lp = 1'b0;
   endtask

   task automatic model_edge(input bit b);
      bit phase, seen, flip, lhit;
      int nm;
      edge_n++;
      phase = (((edge_n - 1 - m_tchg) / BLK) % 2) == 0;
      e_l0 = (m_mode == 1) || (m_mode == 3) ||
             ((m_mode == 4 || m_mode == 5) && phase);
      e_l1 = (m_mode == 2) || (m_mode == 3) ||
             (m_mode == 4 && !phase) || (m_mode == 5 && phase);
      e_pp = m_rose;
      lhit = LP_EN && m_stable && (edge_n - m_rise_edge == LNG);
      e_lp = lhit;
      if (m_mode > 5 || lhit) nm = 0;
      else if (m_rose) nm = (m_mode + 1) % 6;
      else nm = m_mode;
      if (nm != m_mode) m_tchg = edge_n;
      m_mode = nm;
      seen = (b_hist.size() == 2) ? b_hist[0] : 1'b0;
      b_hist.push_back(b);
      if (b_hist.size() > 2) void'(b_hist.pop_front());
      seen_q.push_back(seen);
      if (seen_q.size() > DEB) void'(seen_q.pop_front());
      flip = (seen_q.size() == DEB);
      foreach (seen_q[i]) if (seen_q[i] == m_stable) flip = 1'b0;
      if (flip) m_stable = !m_stable;
      m_rose = flip && m_stable;
      if (m_rose) m_rise_edge = edge_n;
   endtask

   task automatic tick(input bit b);
      push_button = b;
      @(posedge clk);
      model_edge(b);
      @(negedge clk);
      if (press_pulse) pp_seen++;
      if (long_press) lp_seen++;
      check("mode", mode, m_mode);
      check("led0", led_on_0, e_l0);
      check("led1", led_on_1, e_l1);
      check("press_pulse", press_pulse, e_pp);
      check("long_press", long_press, e_lp);
   endtask

   task automatic press(input int hi, input int lo);
      repeat (hi) tick(1'b1);
      repeat (lo) tick(1'b0);
   endtask

   task automatic press_wait();
      int k;
      k = 0;
      do begin
         tick(1'b1);
         k++;
      end while (!press_pulse && k < 12);
      check("press_seen", press_pulse, 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_mode"}, mode, 0);
      check({tag, "_led0"}, led_on_0, 0);
      check({tag, "_led1"}, led_on_1, 0);
      check({tag, "_pp"}, press_pulse, 0);
      check({tag, "_lp"}, long_press, 0);
   endtask

   // caller sits on a falling edge; reset rises mid-cycle
   task automatic reset_mid(input bit stop_clk);
      if (stop_clk) clk_run = 1'b0;
      #3 rst = 1'b1;
      #1 check_zero(stop_clk ? "rst_stopped" : "rst_running");
      model_reset();
      if (stop_clk) begin
         #19 rst = 1'b0;
         #1 clk_run = 1'b1;
      end else begin
         @(negedge clk);
         @(negedge clk);
         rst = 1'b0;
      end
   endtask

   typedef struct {
      int m;
      bit chk;
      bit l0;
      bit l1;
   } vec_t;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[6];
      bit   on_pat[12];
      int   idx, lidx, n, len;
      bit   lvl;

      tbl = '{'{1, 1, 1, 0}, '{2, 1, 0, 1}, '{3, 1, 1, 1},
              '{4, 0, 0, 0}, '{5, 0, 0, 0}, '{0, 1, 0, 0}};
      on_pat = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};

      repeat (2) @(negedge clk);
      check_zero("por");
      rst = 1'b0;
      model_reset();
      repeat (5) tick(1'b0);

      press(10, 10);
      reset_mid(1'b1);
      repeat (5) tick(1'b0);

      pp_seen = 0;
      repeat (5) begin
         repeat (3) tick(1'b1);
         tick(1'b0);
      end
      check("glitch_pp", pp_seen, 0);
      check("glitch_mode", mode, 0);
      idx = 0;
      for (int i = 1; i <= 8; i++) begin
         tick(1'b1);
         if (press_pulse && idx == 0) idx = i;
      end
      check("press_latency", idx, 7);
      check("first_mode", mode, 1);
      check("first_led0", led_on_0, 1);
      check("first_led1", led_on_1, 0);
      repeat (10) tick(1'b0);

      reset_mid(1'b0);
      for (int i = 0; i < 6; i++) begin
         press(10, 10);
         check("cyc_mode", mode, tbl[i].m);
         if (tbl[i].chk) begin
            check("cyc_led0", led_on_0, tbl[i].l0);
            check("cyc_led1", led_on_1, tbl[i].l1);
         end
      end

      reset_mid(1'b0);
      repeat (3) press(10, 10);
      press_wait();
      check("alt_mode", mode, 4);
      for (int k = 0; k < 12; k++) begin
         tick(1'b1);
         check("alt_led0", led_on_0, on_pat[k]);
         check("alt_led1", led_on_1, !on_pat[k]);
      end
      repeat (10) tick(1'b0);
      press_wait();
      check("blink_mode", mode, 5);
      for (int k = 0; k < 12; k++) begin
         tick(1'b1);
         check("blink_led0", led_on_0, on_pat[k]);
         check("blink_led1", led_on_1, on_pat[k]);
      end
      repeat (10) tick(1'b0);

      reset_mid(1'b0);
      pp_seen = 0;
      lp_seen = 0;
      lidx = 0;
      for (int i = 1; i <= 100; i++) begin
         tick(1'b1);
         if (long_press && lidx == 0) lidx = i;
      end
      check("hold_pp", pp_seen, 1);
`ifdef LONG_PRESS_EN
      check("hold_mode", mode, 0);
      check("hold_lp", lp_seen, 1);
      check("hold_lp_edge", lidx, 2 + DEB + LNG);
`else
      check("hold_mode", mode, 1);
      check("hold_lp", lp_seen, 0);
`endif
      repeat (10) tick(1'b0);
      check("hold_release_pp", pp_seen, 1);

      repeat (3) tick(1'b1);
      reset_mid(1'b0);
      idx = 0;
      for (int i = 1; i <= 8; i++) begin
         tick(1'b1);
         if (press_pulse && idx == 0) idx = i;
      end
      check("rst_hold_latency", idx, 7);
      check("rst_hold_mode", mode, 1);
      repeat (10) tick(1'b0);

      press(10, 10);
      check("pre_illegal_mode", mode, 2);
      force dut.mode_q = 3'd6;
      m_mode = 6;
      #1 release dut.mode_q;
      tick(1'b0);
      check("illegal_mode", mode, 0);
      tick(1'b0);
      check("illegal_led0", led_on_0, 0);
      check("illegal_led1", led_on_1, 0);

      lvl = 1'b0;
      n = 0;
      while (n < 1500) begin
         lvl = !lvl;
         if ($urandom_range(0, 7) == 0) len = $urandom_range(20, 40);
         else len = $urandom_range(1, 8);
         repeat (len) tick(lvl);
         n += len;
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
Controller that sequences the two board LEDs from a single active-high push button. It synchronises and debounces the button. Each clean press advances a mode state machine, and the block drives both LEDs per mode, including timed blink patterns. It sits between the inverted key input and the LED0/LED1 pins, taking the place of a direct button-to-LED mapping.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive cycles the synchronised input must differ from the debounced level before that level flips (20 ms at 50 MHz); minimum 2.
BLINK_CYCLES, 12500000, half-period of the blink/alternate patterns in clk cycles (0.25 s); minimum 2.
LONG_PRESS_CYCLES, 100000000, hold time that forces mode OFF (2 s); used only with LONG_PRESS_EN.

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  asynchronous active-high reset
push_button  input  1  raw active-high button, asynchronous to clk
led_on_0  output  1  LED0 drive, registered
led_on_1  output  1  LED1 drive, registered
mode  output  3  current mode encoding, registered
press_pulse  output  1  one-cycle strobe per debounced press
long_press  output  1  one-cycle strobe on long press; constant 0 without LONG_PRESS_EN

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst. While rst=1, all registers are cleared: sync flops, debounce counter, debounced level, mode=0, blink counter=0, phase=1, led_on_0=0, led_on_1=0, press_pulse=0, long_press=0.
- Synchroniser: two flops on push_button (sync1 -> sync2). No logic sits between them.
- Debounce:
  - The counter increments on each edge where sync2 != stable and clears on any edge where sync2 == stable.
  - When the counter would reach DEBOUNCE_CYCLES, stable toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES consecutive cycles never changes stable.
- Press detect: press_pulse=1 for exactly one cycle, on the edge after stable goes 0->1. Releases produce no pulse.
- Mode FSM, advanced on the same edge that asserts press_pulse:
  - Sequence: OFF(0) -> L0(1) -> L1(2) -> BOTH(3) -> ALT(4) -> BLINK(5) -> OFF(0).
  - Encodings 6 and 7 are illegal and recover to OFF on the next edge.
- Blink timer:
  - The counter runs 0..BLINK_CYCLES-1 and wraps.
  - phase toggles on each wrap.
  - Counter is cleared to 0 and phase set to 1 on every mode change, so each pattern starts with its "on" half.
- LED map, registered one cycle after mode:
  - OFF: 0/0
  - L0: 1/0
  - L1: 0/1
  - BOTH: 1/1
  - ALT: phase/~phase
  - BLINK: phase/phase
- Latency: from a clean push_button rise to the mode change is 2 + DEBOUNCE_CYCLES + 1 edges. The LEDs change one edge later.
- Held button: produces exactly one advance. A new press requires stable to return to 0 first.
- Reset mid-operation: takes effect immediately. Any debounce in progress is discarded, so a button held through reset release is seen as a fresh press once debounced.

Optional Feature:
LONG_PRESS_EN
- Defined:
  - A hold counter increments while stable=1 and clears while stable=0.
  - When it reaches LONG_PRESS_CYCLES, mode is forced to OFF (LEDs 0/0 one edge later) and long_press pulses for one cycle.
  - The counter then saturates, so there is no repeat until release.
  - The short-press advance on the rising edge of stable still happens first.
- Undefined: no hold counter is built, long_press is tied to 0, and hold time is irrelevant.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, BLINK_CYCLES=3, LONG_PRESS_CYCLES=20.
- Reset: assert rst mid-cycle, with clk both running and stopped -> all outputs 0 and mode=0 immediately; after release, LEDs stay 0/0 with the button idle.
- Debounce: button pulses high for 3 cycles, repeated 5 times with 1 cycle low between -> no press_pulse, mode stays 0. Then hold high -> press_pulse exactly 7 edges after the rise, mode=1, next edge LEDs=1/0.
- Full cycle: 6 clean presses, each held 10 and released 10 cycles -> mode sequence 1,2,3,4,5,0; LEDs 1/0, 0/1, 1/1, then ALT, then BLINK, then 0/0.
- ALT/BLINK timing: in ALT, observe 12 cycles -> LEDs hold 1/0 for 3 cycles, then 0/1 for 3, repeating. In BLINK -> 1/1 for 3, 0/0 for 3.
- Held press: hold button 100 cycles from mode 0 -> a single press_pulse and mode=1. With LONG_PRESS_EN: long_press fires 20 cycles after stable rises, mode returns to 0, and there is no further pulse before release.
- Illegal state: force mode=6 via the bench -> mode=0 and LEDs 0/0 within 2 edges.
